// File: rtl/com_pkg.sv
// Shared definitions for the COM FIFO controller: status bit positions,
// register-select encodings, TX state encoding and the status word builder.
package com_pkg;

  // Register select (physical address bit 2)
  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  // Status word bit positions
  localparam int unsigned STAT_TX_NFULL  = 0;
  localparam int unsigned STAT_RX_NEMPTY = 1;
  localparam int unsigned STAT_OVERRUN   = 2;
  localparam int unsigned STAT_RX_IE     = 3;
  localparam int unsigned STAT_TX_IE     = 4;

  // Cycles spent in WAIT_BUSY before giving up on txdBusy_i
  localparam int unsigned TX_BUSY_TIMEOUT = 4;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_START     = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_IDLE = 2'd3
  } tx_state_t;

  function automatic logic [31:0] status_word(input logic tx_nfull,
                                              input logic rx_nempty,
                                              input logic overrun,
                                              input logic rx_ie,
                                              input logic tx_ie);
    logic [31:0] w;
    w                 = '0;
    w[STAT_TX_NFULL]  = tx_nfull;
    w[STAT_RX_NEMPTY] = rx_nempty;
    w[STAT_OVERRUN]   = overrun;
    w[STAT_RX_IE]     = rx_ie;
    w[STAT_TX_IE]     = tx_ie;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output. DEPTH must be a power of
// two (>= 2) so pointers wrap naturally. A simultaneous push and pop always
// both succeed; on an empty FIFO the pushed word passes straight to head.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;
  logic             bypass;
  logic             do_push;
  logic             do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign count = cnt_q;

  // Push and pop on an empty FIFO cancel: the word goes straight through.
  assign bypass  = empty & push & pop;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop) & ~bypass;

  assign head = empty ? din : mem[rd_ptr];

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy update
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/com_fifo_ctrl.sv
// COM port FIFO controller: CPU DATA/STATUS register interface, RX and TX
// byte FIFOs, transmitter handshake FSM and level interrupt.
// Optional: define COM_FIFO_OVERRUN_FLAG_EN for a sticky RX overrun flag
// (status bit2, cleared by a STATUS read).
module com_fifo_ctrl
  import com_pkg::*;
#(
  parameter int unsigned RX_DEPTH = 16,
  parameter int unsigned TX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        readEnable_i,
  input  logic        mode_i,
  input  logic [31:0] dataSave_i,
  output logic [31:0] dataLoad_o,
  output logic        int_o,
  input  logic        rxdReady_i,
  input  logic [7:0]  rxdData_i,
  input  logic        txdBusy_i,
  output logic        txdStart_o,
  output logic [7:0]  txdData_o
);

  localparam logic [1:0] WB_LAST = 2'(TX_BUSY_TIMEOUT - 1);

  logic                      rd_data;
  logic                      rd_status;
  logic                      wr_data;
  logic                      wr_status;

  logic [7:0]                rx_head;
  logic                      rx_full;
  logic                      rx_empty;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic                      rx_pop;

  logic [7:0]                tx_head;
  logic                      tx_full;
  logic                      tx_empty;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic                      tx_pop;

  logic                      rx_ie;
  logic                      tx_ie;
  logic                      ovr_flag;
  tx_state_t                 tx_state;
  logic [1:0]                wb_cnt;

  logic                      unused_ok;

  // Access decode: one strobe cycle is one access
  assign rd_data   = enable_i &  readEnable_i & (mode_i == REG_DATA);
  assign rd_status = enable_i &  readEnable_i & (mode_i == REG_STATUS);
  assign wr_data   = enable_i & ~readEnable_i & (mode_i == REG_DATA);
  assign wr_status = enable_i & ~readEnable_i & (mode_i == REG_STATUS);

  assign rx_pop = rd_data & ~rx_empty;
  assign tx_pop = (tx_state == TX_START);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rxdReady_i),
    .pop   (rx_pop),
    .din   (rxdData_i),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_data),
    .pop   (tx_pop),
    .din   (dataSave_i[7:0]),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  // Read data mux: RX head for DATA, status word for STATUS, else zero
  always_comb begin
    dataLoad_o = '0;
    if (rd_data && !rx_empty) begin
      dataLoad_o = {24'b0, rx_head};
    end else if (rd_status) begin
      dataLoad_o = status_word(~tx_full, ~rx_empty, ovr_flag, rx_ie, tx_ie);
    end
  end

  // Interrupt enables written through STATUS
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ie <= 1'b1;
      tx_ie <= 1'b0;
    end else if (wr_status) begin
      rx_ie <= dataSave_i[STAT_RX_IE];
      tx_ie <= dataSave_i[STAT_TX_IE];
    end
  end

`ifdef COM_FIFO_OVERRUN_FLAG_EN
  logic ovr_q;
  logic rx_drop;

  assign rx_drop = rxdReady_i & rx_full & ~rx_pop;

  // Sticky overrun; a drop coinciding with a STATUS read keeps it set
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= 1'b0;
    end else if (rx_drop) begin
      ovr_q <= 1'b1;
    end else if (rd_status) begin
      ovr_q <= 1'b0;
    end
  end

  assign ovr_flag = ovr_q;
`else
  assign ovr_flag = 1'b0;
`endif

  // Transmit handshake FSM with registered start strobe and data
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state   <= TX_IDLE;
      txdStart_o <= 1'b0;
      txdData_o  <= '0;
      wb_cnt     <= '0;
    end else begin
      txdStart_o <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (!tx_empty && !txdBusy_i) begin
            tx_state   <= TX_START;
            txdStart_o <= 1'b1;
            txdData_o  <= tx_head;
          end
        end
        TX_START: begin
          tx_state <= TX_WAIT_BUSY;
          wb_cnt   <= '0;
        end
        TX_WAIT_BUSY: begin
          if (txdBusy_i) begin
            tx_state <= TX_WAIT_IDLE;
          end else if (wb_cnt == WB_LAST) begin
            tx_state <= TX_IDLE;
          end else begin
            wb_cnt <= wb_cnt + 1'b1;
          end
        end
        TX_WAIT_IDLE: begin
          if (!txdBusy_i) tx_state <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Registered level interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      int_o <= 1'b0;
    end else begin
      int_o <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty & (tx_state == TX_IDLE));
    end
  end

  assign unused_ok = ^{dataSave_i[31:8], rx_count, tx_count, rx_full};

endmodule

// File: tb/tb_com_fifo_ctrl.sv
// Directed bench for com_fifo_ctrl with a simple transmitter busy model.
module tb_com_fifo_ctrl;
  import com_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic        readEnable_i;
  logic        mode_i;
  logic [31:0] dataSave_i;
  logic [31:0] dataLoad_o;
  logic        int_o;
  logic        rxdReady_i;
  logic [7:0]  rxdData_i;
  logic        txdBusy_i = 1'b0;
  logic        txdStart_o;
  logic [7:0]  txdData_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc = 0;
  int          busy_cnt = 0;
  bit          busy_en = 1'b0;
  bit          prev_start = 1'b0;
  logic [7:0]  start_q[$];
  int          start_cyc[$];

`ifdef COM_FIFO_OVERRUN_FLAG_EN
  localparam logic [31:0] ST_RX_FULL_DROP = 32'h0F;
`else
  localparam logic [31:0] ST_RX_FULL_DROP = 32'h0B;
`endif

  com_fifo_ctrl #(
    .RX_DEPTH (16),
    .TX_DEPTH (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
    .readEnable_i (readEnable_i),
    .mode_i       (mode_i),
    .dataSave_i   (dataSave_i),
    .dataLoad_o   (dataLoad_o),
    .int_o        (int_o),
    .rxdReady_i   (rxdReady_i),
    .rxdData_i    (rxdData_i),
    .txdBusy_i    (txdBusy_i),
    .txdStart_o   (txdStart_o),
    .txdData_o    (txdData_o)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Transmitter model: busy for 20 cycles after each start; logs starts
  always @(negedge clk) begin
    if (txdStart_o === 1'b1) begin
      chk("start_not_busy", 32'(txdBusy_i), 32'h0);
      chk("start_width", 32'(prev_start), 32'h0);
      start_q.push_back(txdData_o);
      start_cyc.push_back(cyc);
      busy_cnt = 20;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    prev_start = txdStart_o;
    txdBusy_i  = busy_en && (busy_cnt > 0);
  end

  task automatic bus_write(input logic m, input logic [31:0] d);
    enable_i = 1'b1; readEnable_i = 1'b0; mode_i = m; dataSave_i = d;
    @(negedge clk);
    enable_i = 1'b0; dataSave_i = '0;
  endtask

  task automatic bus_read(input logic m, input logic [31:0] exp, input string tag);
    enable_i = 1'b1; readEnable_i = 1'b1; mode_i = m;
    #1;
    chk(tag, dataLoad_o, exp);
    @(negedge clk);
    enable_i = 1'b0; readEnable_i = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rxdReady_i = 1'b1; rxdData_i = b;
    @(negedge clk);
    rxdReady_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget);
    int g = 0;
    while (start_q.size() < n && g < budget) begin
      @(negedge clk);
      g++;
    end
    chk("start_count", 32'(start_q.size()), 32'(n));
  endtask

  task automatic wait_tx_quiet();
    int g = 0;
    while ((txdBusy_i || busy_cnt > 0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int n0;
    logic [7:0] exp_b[3];
    rst = 1'b1; enable_i = 1'b0; readEnable_i = 1'b0; mode_i = REG_DATA;
    dataSave_i = '0; rxdReady_i = 1'b0; rxdData_i = '0;

    // Reset state
    @(negedge clk);
    chk("rst_start", 32'(txdStart_o), 32'h0);
    chk("rst_data", 32'(txdData_o), 32'h0);
    chk("rst_int", 32'(int_o), 32'h0);
    chk("rst_state", 32'(dut.tx_state), 32'(TX_IDLE));
    @(negedge clk);
    rst = 1'b0;
    bus_read(REG_STATUS, 32'h09, "rst_status");
    bus_read(REG_DATA, 32'h0, "rst_empty_read");

    // Interrupt latency
    rx_byte(8'h55);
    chk("int_not_yet", 32'(int_o), 32'h0);
    @(negedge clk);
    chk("int_rx", 32'(int_o), 32'h1);
    bus_read(REG_DATA, 32'h55, "int_rx_read");
    @(negedge clk);
    chk("int_rx_clear", 32'(int_o), 32'h0);
    bus_write(REG_STATUS, 32'h10);
    @(negedge clk);
    chk("int_tx_idle", 32'(int_o), 32'h1);
    bus_read(REG_STATUS, 32'h11, "status_ie_swap");
    bus_write(REG_STATUS, 32'h08);
    @(negedge clk);
    chk("int_off", 32'(int_o), 32'h0);

    // TX with 20-cycle busy transmitter
    busy_en = 1'b1;
    start_q.delete(); start_cyc.delete();
    bus_write(REG_DATA, 32'h41);
    bus_write(REG_DATA, 32'h42);
    bus_write(REG_DATA, 32'h43);
    wait_starts(3, 400);
    exp_b = '{8'h41, 8'h42, 8'h43};
    for (int i = 0; i < 3; i++)
      chk("tx_busy_byte", (i < start_q.size()) ? 32'(start_q[i]) : 32'hFFFF_FFFF, 32'(exp_b[i]));
    wait_tx_quiet();

    // TX with busy never asserted: WAIT_BUSY timeout path
    busy_en = 1'b0;
    repeat (2) @(negedge clk);
    start_q.delete(); start_cyc.delete();
    bus_write(REG_DATA, 32'h61);
    bus_write(REG_DATA, 32'h62);
    bus_write(REG_DATA, 32'h63);
    wait_starts(3, 100);
    exp_b = '{8'h61, 8'h62, 8'h63};
    for (int i = 0; i < 3; i++)
      chk("tx_to_byte", (i < start_q.size()) ? 32'(start_q[i]) : 32'hFFFF_FFFF, 32'(exp_b[i]));
    if (start_cyc.size() >= 3) begin
      chk("tx_to_gap1", 32'(start_cyc[1] - start_cyc[0]), 32'd6);
      chk("tx_to_gap2", 32'(start_cyc[2] - start_cyc[1]), 32'd6);
    end
    repeat (10) @(negedge clk);

    // RX fill, overflow, drain
    do_reset();
    for (int i = 0; i < 16; i++) rx_byte(8'(i));
    rx_byte(8'hFF);
    bus_read(REG_STATUS, ST_RX_FULL_DROP, "rx_full_status");
    for (int i = 0; i < 16; i++) bus_read(REG_DATA, 32'(i), "rx_drain");
    bus_read(REG_DATA, 32'h0, "rx_empty_read");
    bus_read(REG_STATUS, 32'h09, "rx_ovr_cleared");

    // RX full with read and push in the same cycle
    for (int i = 0; i < 16; i++) rx_byte(8'(8'h20 + i));
    enable_i = 1'b1; readEnable_i = 1'b1; mode_i = REG_DATA;
    rxdReady_i = 1'b1; rxdData_i = 8'hEE;
    #1;
    chk("rx_rdpush_data", dataLoad_o, 32'h20);
    @(negedge clk);
    enable_i = 1'b0; readEnable_i = 1'b0; rxdReady_i = 1'b0;
    chk("rx_rdpush_count", 32'(dut.u_rx_fifo.count), 32'd16);
    bus_read(REG_STATUS, 32'h0B, "rx_rdpush_status");
    for (int i = 1; i < 16; i++) bus_read(REG_DATA, 32'(8'h20 + i), "rx_rdpush_drain");
    bus_read(REG_DATA, 32'hEE, "rx_rdpush_last");
    bus_read(REG_DATA, 32'h0, "rx_rdpush_empty");

`ifdef COM_FIFO_OVERRUN_FLAG_EN
    // Drop coinciding with a STATUS read keeps the flag
    for (int i = 0; i < 16; i++) rx_byte(8'(i));
    enable_i = 1'b1; readEnable_i = 1'b1; mode_i = REG_STATUS;
    rxdReady_i = 1'b1; rxdData_i = 8'hAA;
    #1;
    chk("ovr_race_read", dataLoad_o, 32'h0B);
    @(negedge clk);
    enable_i = 1'b0; readEnable_i = 1'b0; rxdReady_i = 1'b0;
    bus_read(REG_STATUS, 32'h0F, "ovr_race_kept");
`endif

    // Reset during WAIT_IDLE with bytes queued
    do_reset();
    busy_en = 1'b1;
    wait_tx_quiet();
    start_q.delete(); start_cyc.delete();
    for (int i = 0; i < 6; i++) bus_write(REG_DATA, 32'(8'h81 + i));
    repeat (3) @(negedge clk);
    chk("abort_pre_state", 32'(dut.tx_state), 32'(TX_WAIT_IDLE));
    chk("abort_pre_count", 32'(dut.u_tx_fifo.count), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", 32'(dut.tx_state), 32'(TX_IDLE));
    chk("abort_tx_count", 32'(dut.u_tx_fifo.count), 32'd0);
    chk("abort_rx_count", 32'(dut.u_rx_fifo.count), 32'd0);
    n0 = start_q.size();
    repeat (40) @(negedge clk);
    chk("abort_no_restart", 32'(start_q.size()), 32'(n0));
    bus_write(REG_DATA, 32'h99);
    wait_starts(n0 + 1, 80);
    chk("abort_new_byte", (start_q.size() > n0) ? 32'(start_q[n0]) : 32'hFFFF_FFFF, 32'h99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/com_fifo_ctrl.md
COM_FIFO_CTRL -- requirements
Module: com_fifo_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset named rst; all state SHALL change only on posedge clk.
REQ-002 Parameter RX_DEPTH, default 16, SHALL set the receive FIFO depth in bytes; it SHALL be a power of two and at least 2.
REQ-003 Parameter TX_DEPTH, default 16, SHALL set the transmit FIFO depth in bytes; it SHALL be a power of two and at least 2.
REQ-004 The block SHALL have the following ports:
- clk  in  1  25 MHz system clock
- rst  in  1  synchronous active-high reset
- enable_i  in  1  device-access strobe from devctrl
- readEnable_i  in  1  1 = read, 0 = write
- mode_i  in  1  register select (physical address bit 2): 0 = DATA, 1 = STATUS/CTRL
- dataSave_i  in  32  write data from the CPU
- dataLoad_o  out  32  read data to the CPU
- int_o  out  1  level interrupt to the CPU (int[2])
- rxdReady_i  in  1  one-cycle pulse: receiver has a byte
- rxdData_i  in  8  received byte
- txdBusy_i  in  1  transmitter busy
- txdStart_o  out  1  one-cycle transmit start
- txdData_o  out  8  byte to transmit

Function
REQ-005 Each cycle with enable_i=1 SHALL count as exactly one access; devctrl guarantees single-cycle strobes.
REQ-006 A DATA read SHALL drive dataLoad_o = {24'b0, RX head} combinationally in the same cycle and SHALL pop the RX FIFO at the clock edge; if the RX FIFO is empty, dataLoad_o SHALL be 0 and no pop SHALL occur.
REQ-007 A DATA write SHALL push dataSave_i[7:0] into the TX FIFO; a write to a full TX FIFO SHALL be discarded.
REQ-008 A STATUS read SHALL return the following bits, with all other bits 0:
- bit0 = TX FIFO not full
- bit1 = RX FIFO not empty
- bit2 = overrun flag (REQ-019)
- bits[4:3] = {txIe, rxIe}
REQ-009 A STATUS write SHALL load rxIe <= dataSave_i[3] and txIe <= dataSave_i[4]; all other bits SHALL be ignored.
REQ-010 An rxdReady_i pulse SHALL push rxdData_i into the RX FIFO if it is not full; otherwise the byte SHALL be dropped.
REQ-011 A push and a pop on the same FIFO in the same cycle SHALL both succeed, including when the FIFO is full or empty-with-push, and the count SHALL be unchanged.
REQ-012 FIFO pointers SHALL wrap modulo depth; counts SHALL be clog2(depth)+1 bits wide.
REQ-013 The TX state machine SHALL have four states with the following transitions:
- IDLE: if the TX FIFO is not empty and txdBusy_i=0, go to START.
- START: assert txdStart_o for exactly one cycle with txdData_o = TX head, pop the TX FIFO, then go to WAIT_BUSY.
- WAIT_BUSY: go to WAIT_IDLE when txdBusy_i=1, or after 4 cycles without it (timeout).
- WAIT_IDLE: go to IDLE when txdBusy_i=0.
REQ-014 Successive bytes SHALL therefore be separated by at least one IDLE cycle.
REQ-015 txdData_o SHALL hold the last started byte outside START.
REQ-016 int_o SHALL be registered (1-cycle latency) and equal (rxIe & RX not empty) | (txIe & TX empty & state==IDLE).

Reset
REQ-017 The following SHALL hold on reset:
- both FIFOs empty (pointers and counts 0)
- TX state IDLE
- txdStart_o = 0, txdData_o = 0, int_o = 0
- rxIe = 1, txIe = 0
- overrun flag = 0
REQ-018 Reset asserted mid-transmission SHALL abort the state machine to IDLE; the byte already handed to the transmitter completes externally and is not retransmitted.

Configuration
REQ-019 With macro COM_FIFO_OVERRUN_FLAG_EN defined, a byte dropped per REQ-010 SHALL set a sticky overrun flag that is cleared by a STATUS read; a drop and a STATUS read in the same cycle SHALL leave the flag set.
REQ-020 Without COM_FIFO_OVERRUN_FLAG_EN, status bit2 SHALL read 0 and no flag register SHALL exist.

Structure
REQ-021 Status bit positions, register-select encodings and TX state encodings SHALL reside in shared package com_pkg.
REQ-022 Both FIFOs SHALL be instances of one sub-module sync_fifo, parametrised by width (8) and depth, exposing push, pop, head, full, empty and count.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Write 0x41, 0x42, 0x43 to DATA with txdBusy_i modelled at 20 cycles per byte -> three txdStart_o pulses in order 0x41, 0x42, 0x43, each one cycle wide, never while busy.
- Push 16 rxdReady_i bytes 0x00..0x0F with RX_DEPTH=16, then a 17th byte 0xFF -> STATUS = 0x0F (0x0B if the macro is undefined); 16 DATA reads return 0x00..0x0F; the next read returns 0.
- RX full, with a DATA read and an rxdReady_i pulse in the same cycle -> no drop, count stays 16, overrun bit unchanged.
- After reset, rxdReady_i byte 0x55 -> int_o=1 two cycles after the pulse; DATA read -> int_o=0 one cycle later; STATUS write 0x10 with TX idle and empty -> int_o=1.
- Assert rst during WAIT_IDLE with 5 bytes queued -> next cycle state IDLE, FIFOs empty, txdStart_o never pulses again until a new write.
- Hold txdBusy_i=0 permanently -> the WAIT_BUSY timeout returns to IDLE, and 3 queued bytes are started 6 cycles apart.
